// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and helpers for the BTB update scheduler: FSM encoding,
// queued-update layout and a priority encoder used for way selection.
package btb_update_ctrl_pkg;

  localparam int BTB_WAY    = 8;
  localparam int BTB_UPD_WD = 65;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_WRITE = 2'd2,
    ST_SWEEP = 2'd3
  } btb_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic [31:0] target;
  } btb_upd_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/btb_update_ctrl_plru_tree.sv
// Tree pseudo-LRU replacement state for a fully associative BTB.
// Node i has children 2i+1 (left, bit=0) and 2i+2 (right, bit=1).
module plru_tree #(
  parameter int NWAY = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    touch_en,
  input  logic [$clog2(NWAY)-1:0] touch_way,
  output logic [$clog2(NWAY)-1:0] victim_way
);

  localparam int WAYW = $clog2(NWAY);
  localparam logic [WAYW:0] LEAF_BASE = (WAYW+1)'(NWAY - 1);
  localparam logic [WAYW:0] ONE       = (WAYW+1)'(1);
  localparam logic [WAYW:0] TWO       = (WAYW+1)'(2);

  logic [NWAY-2:0] bits_q;
  logic [NWAY-2:0] bits_d;

  // Victim walk from the root down to a leaf
  always_comb begin : victim_walk
    logic [WAYW:0] node;
    node = '0;
    for (int l = 0; l < WAYW; l++) begin
      if (bits_q[node[WAYW-1:0]]) begin
        node = {node[WAYW-1:0], 1'b0} + TWO;
      end else begin
        node = {node[WAYW-1:0], 1'b0} + ONE;
      end
    end
    victim_way = WAYW'(node - LEAF_BASE);
  end

  // Touch: every node on the leaf's path points away from it (a left child sets its parent to 1)
  always_comb begin : touch_update
    logic [WAYW:0]   node;
    logic [WAYW-1:0] pidx;
    bits_d = bits_q;
    node   = {1'b0, touch_way} + LEAF_BASE;
    pidx   = '0;
    if (clr) begin
      bits_d = '0;
    end else if (touch_en) begin
      for (int l = 0; l < WAYW; l++) begin
        pidx         = WAYW'((node - ONE) >> 1);
        bits_d[pidx] = node[0];
        node         = {1'b0, pidx};
      end
    end else begin
      bits_d = bits_q;
    end
  end

  // Replacement state register
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: queues resolved branches, probes for an existing
// entry, picks hit-way or PLRU victim, and sequences full invalidate sweeps.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int NWAY   = BTB_WAY,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic [31:0]             upd_target,
  input  logic                    upd_taken,
  output logic                    upd_ready,
  input  logic                    inval_all,
  input  logic [NWAY-1:0]         lookup_hit_way,
  output logic [31:0]             probe_pc,
  input  logic [NWAY-1:0]         probe_hit_way,
  output logic                    btb_we,
  output logic [$clog2(NWAY)-1:0] btb_way,
  output logic [31:0]             btb_pc,
  output logic [31:0]             btb_target,
  output logic                    btb_vbit,
  output logic                    busy
);

  localparam int WAYW = $clog2(NWAY);
  localparam int PTRW = $clog2(QDEPTH);
  localparam logic [PTRW:0]   Q_FULL   = (PTRW+1)'(QDEPTH);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [WAYW-1:0] LAST_WAY = WAYW'(NWAY - 1);
  localparam logic [WAYW-1:0] WAY_ONE  = WAYW'(1);

  btb_state_e            state_q, state_d;
  logic [BTB_UPD_WD-1:0] queue_q [QDEPTH];
  logic [PTRW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTRW:0]         count_q, count_d;
  logic                  sweep_pend_q, sweep_pend_d;
  logic [WAYW-1:0]       sweep_cnt_q, sweep_cnt_d;
  logic [WAYW-1:0]       way_sel_q, way_sel_d;

  btb_upd_t        head_s;
  logic            push_s, pop_s;
  logic            sweep_req_s, sweep_start_s;
  logic            probe_hit_s;
  logic [WAYW-1:0] probe_idx_s, lookup_idx_s, victim_s, touch_way_s;
  logic            touch_en_s, plru_clr_s;

  assign head_s       = btb_upd_t'(queue_q[rd_ptr_q]);
  assign upd_ready    = (count_q != Q_FULL);
  assign push_s       = upd_valid & upd_ready;
  assign probe_hit_s  = |probe_hit_way;
  assign probe_idx_s  = WAYW'(lowest_set_idx(32'(probe_hit_way)));
  assign lookup_idx_s = WAYW'(lowest_set_idx(32'(lookup_hit_way)));
  assign sweep_req_s  = sweep_pend_q | inval_all;
  assign busy         = (count_q != '0) | (state_q != ST_IDLE) | sweep_pend_q;

  // FSM next state, way selection and BTB port outputs
  always_comb begin
    state_d       = state_q;
    way_sel_d     = way_sel_q;
    sweep_cnt_d   = sweep_cnt_q;
    pop_s         = 1'b0;
    sweep_start_s = 1'b0;
    plru_clr_s    = 1'b0;
    probe_pc      = 32'h0;
    btb_we        = 1'b0;
    btb_way       = '0;
    btb_pc        = 32'h0;
    btb_target    = 32'h0;
    btb_vbit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sweep_req_s) begin
          state_d       = ST_SWEEP;
          sweep_cnt_d   = '0;
          sweep_start_s = 1'b1;
        end else if ((count_q != '0) || push_s) begin
          // a push into an empty queue is visible at the head next cycle
          state_d = ST_PROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROBE: begin
        probe_pc  = head_s.pc;
        way_sel_d = probe_hit_s ? probe_idx_s : victim_s;
        if (!probe_hit_s && !head_s.taken) begin
          pop_s   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        btb_we     = 1'b1;
        btb_way    = way_sel_q;
        btb_pc     = head_s.pc;
        btb_target = head_s.target;
        btb_vbit   = head_s.taken;
        pop_s      = 1'b1;
        if (sweep_req_s) begin
          state_d       = ST_SWEEP;
          sweep_cnt_d   = '0;
          sweep_start_s = 1'b1;
        end else if ((count_q > CNT_ONE) || push_s) begin
          state_d = ST_PROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        btb_we  = 1'b1;
        btb_way = sweep_cnt_q;
        if (sweep_cnt_q == LAST_WAY) begin
          state_d     = ST_IDLE;
          sweep_cnt_d = '0;
          plru_clr_s  = 1'b1;
        end else begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = sweep_cnt_q + WAY_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Starting a sweep consumes the request; one arriving mid-sweep re-arms another
  always_comb begin
    if (sweep_start_s) begin
      sweep_pend_d = 1'b0;
    end else begin
      sweep_pend_d = sweep_pend_q | inval_all;
    end
  end

  // Queue pointer and occupancy update
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // PLRU touch source: a valid write beats a fetch-side hit; sweeps never touch
  always_comb begin
    if ((state_q == ST_WRITE) && head_s.taken) begin
      touch_en_s  = 1'b1;
      touch_way_s = way_sel_q;
    end else if ((state_q != ST_SWEEP) && (|lookup_hit_way)) begin
      touch_en_s  = 1'b1;
      touch_way_s = lookup_idx_s;
    end else begin
      touch_en_s  = 1'b0;
      touch_way_s = '0;
    end
  end

  plru_tree #(
    .NWAY(NWAY)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .clr       (plru_clr_s),
    .touch_en  (touch_en_s),
    .touch_way (touch_way_s),
    .victim_way(victim_s)
  );

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      sweep_pend_q <= 1'b0;
      sweep_cnt_q  <= '0;
      way_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sweep_pend_q <= sweep_pend_d;
      sweep_cnt_q  <= sweep_cnt_d;
      way_sel_q    <= way_sel_d;
    end
  end

  // Update queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else if (push_s) begin
      queue_q[wr_ptr_q] <= {upd_taken, upd_pc, upd_target};
    end else begin
      queue_q[wr_ptr_q] <= queue_q[wr_ptr_q];
    end
  end

endmodule
